// File: rtl/main_memory_ctrl_pkg.sv
// Shared types and constants for the line-granular main-memory controller.
package main_memory_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam int DEF_LINE_ADDR_LEN = 3;
  localparam int DEF_LINE_SIZE     = 1 << DEF_LINE_ADDR_LEN;
  localparam int WORD_OFS_W        = DEF_LINE_ADDR_LEN;
  localparam int WORD_ADDR_LEN     = 2;

  // Word 0 sits in the most significant 32 bits of a line.
  function automatic int word_lsb(input int k, input int line_size);
    return 32 * (line_size - 1 - k);
  endfunction

endpackage

// File: rtl/RAM.sv
// Word-wide memory model: write on the clock edge, combinational read of the registered address.
module RAM #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        debug,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        write,
  output logic [31:0] rdata
);

  logic [31:0] mem [1<<DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (write) mem[addr[DEPTH_LOG2+1:2]] <= wdata;
  end

  assign rdata = mem[addr[DEPTH_LOG2+1:2]];

  logic unused_bits;
  assign unused_bits = &{1'b0, debug, addr[31:DEPTH_LOG2+2], addr[1:0]};

endmodule

// File: rtl/main_memory_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter; search starts one past the last granted port.
module main_memory_ctrl_rr_arbiter #(
  parameter int N_PORTS = 2,
  parameter int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [N_PORTS-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               valid
);

  int idx;

  // Walk from the farthest offset back so the nearest requester overrides.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    idx       = 0;
    for (int i = N_PORTS; i >= 1; i--) begin
      idx = (int'(last) + i) % N_PORTS;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/main_memory_ctrl.sv
// Multi-port line controller: round-robin grant, word-serial RAM access, fixed completion latency.
module main_memory_ctrl
  import main_memory_ctrl_pkg::*;
#(
  parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
  parameter int N_PORTS       = 2,
  parameter int LATENCY       = 17
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      debug,
  input  logic [N_PORTS-1:0]                        rd_req,
  input  logic [N_PORTS-1:0]                        wr_req,
  input  logic [32*N_PORTS-1:0]                     addr,
  input  logic [32*(1<<LINE_ADDR_LEN)*N_PORTS-1:0]  wdata,
  input  logic [(1<<LINE_ADDR_LEN)*N_PORTS-1:0]     wmask,
  output logic [N_PORTS-1:0]                        done,
  output logic [32*(1<<LINE_ADDR_LEN)-1:0]          rdata,
  output logic                                      busy
);

  localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
  localparam int LINE_BITS = 32 * LINE_SIZE;
  localparam int IDX_W     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CNT_W     = $clog2(LATENCY + 1);
  localparam int TAG_W     = 28 - LINE_ADDR_LEN - WORD_ADDR_LEN;
  localparam logic [CNT_W-1:0] CNT_LINE = CNT_W'(LINE_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  if (LATENCY < LINE_SIZE + 2) begin : g_bad_latency
    $error("main_memory_ctrl: LATENCY must be at least LINE_SIZE+2");
  end

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [IDX_W-1:0]         last;
  logic [N_PORTS-1:0]       cur_oh;
  logic                     cur_rd;
  logic [TAG_W-1:0]         cur_tag;
  logic [LINE_BITS-1:0]     cur_wdata;
  logic [LINE_SIZE-1:0]     cur_mask;
  logic [LINE_BITS-1:0]     line_buf;
  logic [31:0]              ram_addr;
  logic [31:0]              ram_wdata;
  logic                     ram_write;
  logic [31:0]              ram_rdata;

  logic [N_PORTS-1:0]       arb_oh;
  logic [IDX_W-1:0]         arb_idx;
  logic                     arb_valid;
  logic [CNT_W-1:0]         cnt_m1;
  logic [LINE_ADDR_LEN-1:0] k_drv;
  logic [LINE_ADDR_LEN-1:0] k_cap;

  assign cnt_m1 = cnt - CNT_W'(1);
  assign k_drv  = cnt[LINE_ADDR_LEN-1:0];
  assign k_cap  = cnt_m1[LINE_ADDR_LEN-1:0];
  assign busy   = (state != ST_IDLE);

  main_memory_ctrl_rr_arbiter #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (rd_req | wr_req),
    .last      (last),
    .grant     (arb_oh),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  RAM u_ram (
    .clk   (clk),
    .debug (debug),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .write (ram_write),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      last      <= IDX_W'(N_PORTS - 1);
      cur_oh    <= '0;
      cur_rd    <= 1'b0;
      cur_tag   <= '0;
      cur_wdata <= '0;
      cur_mask  <= '0;
      line_buf  <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_write <= 1'b0;
      done      <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            state     <= ST_ACCESS;
            last      <= arb_idx;
            cur_oh    <= arb_oh;
            cur_rd    <= rd_req[arb_idx];
            cur_tag   <= addr[32*int'(arb_idx) + LINE_ADDR_LEN + WORD_ADDR_LEN +: TAG_W];
            cur_wdata <= wdata[LINE_BITS*int'(arb_idx) +: LINE_BITS];
            cur_mask  <= wmask[LINE_SIZE*int'(arb_idx) +: LINE_SIZE];
            cnt       <= '0;
          end
        end
        ST_ACCESS: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt < CNT_LINE) begin
            ram_addr  <= {4'b0, cur_tag, k_drv, 2'b00};
            ram_wdata <= cur_wdata[word_lsb(int'(k_drv), LINE_SIZE) +: 32];
            ram_write <= ~cur_rd & cur_mask[k_drv];
          end else begin
            ram_write <= 1'b0;
            state     <= ST_WAIT;
          end
          // Read data trails the driven address by one cycle.
          if (cur_rd && cnt != '0)
            line_buf[word_lsb(int'(k_cap), LINE_SIZE) +: 32] <= ram_rdata;
        end
        ST_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state <= ST_DONE;
            done  <= cur_oh;
            if (cur_rd) rdata <= line_buf;
          end
        end
        ST_DONE: begin
          done  <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Directed and randomized checks of main_memory_ctrl against a word-array memory model.
module tb_main_memory_ctrl;

  localparam int LAL = 3;
  localparam int NP  = 2;
  localparam int LAT = 17;
  localparam int LS  = 1 << LAL;
  localparam int LB  = 32 * LS;

  logic              clk = 1'b0;
  logic              rst;
  logic              debug;
  logic [NP-1:0]     rd_req;
  logic [NP-1:0]     wr_req;
  logic [32*NP-1:0]  addr;
  logic [LB*NP-1:0]  wdata;
  logic [LS*NP-1:0]  wmask;
  logic [NP-1:0]     done;
  logic [LB-1:0]     rdata;
  logic              busy;

  main_memory_ctrl #(
    .LINE_ADDR_LEN (LAL),
    .N_PORTS       (NP),
    .LATENCY       (LAT)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .debug  (debug),
    .rd_req (rd_req),
    .wr_req (wr_req),
    .addr   (addr),
    .wdata  (wdata),
    .wmask  (wmask),
    .done   (done),
    .rdata  (rdata),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0]   mem [int];
  logic [LB-1:0] model_rdata = '0;
  int            model_last = NP - 1;

  task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int widx(input logic [31:0] a, input int k);
    return int'((a & 32'h0FFF_FFFF) >> (LAL + 2)) * LS + k;
  endfunction

  function automatic logic [LB-1:0] model_line(input logic [31:0] a);
    logic [LB-1:0] l;
    l = 'x;
    for (int k = 0; k < LS; k++)
      if (mem.exists(widx(a, k))) l[LB-1-32*k -: 32] = mem[widx(a, k)];
    return l;
  endfunction

  function automatic logic [NP-1:0] onehot(input int p);
    logic [NP-1:0] o;
    o = '0;
    o[p] = 1'b1;
    return o;
  endfunction

  function automatic int rr_next(input int lst, input logic [NP-1:0] req);
    for (int i = 1; i <= NP; i++)
      if (req[(lst + i) % NP]) return (lst + i) % NP;
    return -1;
  endfunction

  task automatic do_txn(input int p, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [LB-1:0] wl, input logic [LS-1:0] m, input string tag);
    int  t0;
    bit  seen;
    addr[32*p +: 32]  = a;
    wdata[LB*p +: LB] = wl;
    wmask[LS*p +: LS] = m;
    rd_req[p] = rd;
    wr_req[p] = wr;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      if (busy) seen = 1;
    end
    t0 = cyc;
    if (!seen) chk({tag, "_accept"}, LB'(busy), LB'(1'b1));
    seen = 0;
    for (int i = 0; i < LAT + 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (done != '0) seen = 1;
    end
    chk({tag, "_done_port"}, LB'(done), LB'(onehot(p)));
    chk({tag, "_latency"}, LB'(cyc - t0), LB'(LAT));
    rd_req[p] = 1'b0;
    wr_req[p] = 1'b0;
    model_last = p;
    if (rd) begin
      model_rdata = model_line(a);
    end else begin
      for (int k = 0; k < LS; k++)
        if (m[k]) mem[widx(a, k)] = wl[LB-1-32*k -: 32];
    end
    chk({tag, "_rdata"}, rdata, model_rdata);
  endtask

  logic [LB-1:0] line;
  logic [31:0]   bases [4] = '{32'h100, 32'h200, 32'h400, 32'h480};

  initial begin
    rst = 1'b0; debug = 1'b0;
    rd_req = '0; wr_req = '0; addr = '0; wdata = '0; wmask = '0;
    #12;
    chk("rst_done", LB'(done), '0);
    chk("rst_rdata", rdata, '0);
    chk("rst_busy", LB'(busy), '0);
    chk("rst_ram_write", LB'(u_dut.ram_write), '0);
    @(negedge clk); rst = 1'b1;

    for (int k = 0; k < LS; k++) line[LB-1-32*k -: 32] = 32'(k + 1);
    do_txn(0, 0, 1, 32'h100, line, '1, "wr_full");
    do_txn(0, 1, 0, 32'h100, '0, '0, "rd_full");
    chk("rd_full_word0", LB'(rdata[LB-1 -: 32]), LB'(32'h1));

    for (int k = 0; k < LS; k++) line[LB-1-32*k -: 32] = 32'hA0 + 32'(k);
    do_txn(0, 0, 1, 32'h100, line, 8'h05, "wr_mask");
    do_txn(0, 1, 0, 32'h100, '0, '0, "rd_mask");

    do_txn(1, 1, 0, 32'h1000_0104, '0, '0, "rd_alias");

    for (int b = 1; b < 4; b++) begin
      for (int k = 0; k < LS; k++) line[LB-1-32*k -: 32] = $urandom;
      do_txn(b % NP, 0, 1, bases[b], line, '1, "wr_init");
    end

    for (int k = 0; k < LS; k++) line[LB-1-32*k -: 32] = 32'hDEAD_0000 + 32'(k);
    do_txn(0, 1, 1, 32'h200, line, '1, "rd_wins");
    do_txn(1, 1, 0, 32'h200, '0, '0, "rd_after_rw");

    begin : alternate
      int exp_p;
      int prev_done;
      bit seen;
      addr[31:0]  = 32'h100;
      addr[63:32] = 32'h200;
      rd_req = '1;
      exp_p = rr_next(model_last, rd_req);
      prev_done = 0;
      for (int n = 0; n < 4; n++) begin
        seen = 0;
        for (int i = 0; i < 2 * LAT + 10 && !seen; i++) begin
          @(posedge clk); #1;
          if (done != '0) seen = 1;
        end
        chk("alt_done_port", LB'(done), LB'(onehot(exp_p)));
        model_rdata = model_line(exp_p == 0 ? 32'h100 : 32'h200);
        chk("alt_rdata", rdata, model_rdata);
        if (n > 0) chk("alt_spacing", LB'(cyc - prev_done), LB'(LAT + 2));
        prev_done = cyc;
        model_last = exp_p;
        exp_p = rr_next(model_last, rd_req);
      end
      rd_req = '0;
    end

    for (int t = 0; t < 16; t++) begin
      int p;
      bit rd;
      logic [31:0] a;
      p  = $urandom_range(0, NP - 1);
      rd = 1'($urandom_range(0, 1));
      a  = bases[$urandom_range(0, 3)] | 32'($urandom_range(0, 31)) | (32'($urandom_range(0, 15)) << 28);
      for (int k = 0; k < LS; k++) line[LB-1-32*k -: 32] = $urandom;
      do_txn(p, rd, !rd, a, line, LS'($urandom), "rand");
    end

    begin : mid_reset
      bit seen;
      for (int k = 0; k < LS; k++) line[LB-1-32*k -: 32] = 32'h5555_0000 + 32'(k);
      addr[63:32] = 32'h300;
      wdata[LB +: LB] = line;
      wmask[LS +: LS] = '1;
      wr_req[1] = 1'b1;
      seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
        @(posedge clk); #1;
        if (busy) seen = 1;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_busy", LB'(busy), LB'(1'b1));
      rst = 1'b0;
      #1;
      chk("mid_rst_done", LB'(done), '0);
      chk("mid_rst_busy", LB'(busy), '0);
      chk("mid_rst_ram_write", LB'(u_dut.ram_write), '0);
      chk("mid_rst_rdata", rdata, '0);
      wr_req = '0;
      @(negedge clk); rst = 1'b1;
      model_rdata = '0;
      model_last = NP - 1;
    end
    do_txn(0, 1, 0, 32'h400, '0, '0, "rd_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/main_memory_ctrl.md
# main_memory_ctrl

Multi-port, line-granular main-memory controller sitting between the cache hierarchy (I-cache, D-cache, accelerator DMA) and the word-wide `RAM` model. Generalises the single-port line wrapper: parametrised line size, port count and access latency, per-word write masking, round-robin arbitration between requesters, and a fixed, guaranteed completion latency. Exactly one line transfer is in flight at any time.

## Interface
- `LINE_ADDR_LEN`, 3: log2 words per line; `LINE_SIZE = 1<<LINE_ADDR_LEN`
- `N_PORTS`, 2: number of requesters (1..8)
- `LATENCY`, 17: cycles from acceptance edge to `done` edge; must satisfy `LATENCY >= LINE_SIZE+2` (elaboration-time check)
- `clk`  input  1  clock, all state on rising edge
- `rst`  input  1  asynchronous, active-low reset
- `debug`  input  1  forwarded to `RAM`
- `rd_req`  input  N_PORTS  per-port line-read request, level, held until `done`
- `wr_req`  input  N_PORTS  per-port line-write request, level, held until `done`
- `addr`  input  32*N_PORTS  per-port byte address; port p in bits [32p+31:32p]
- `wdata`  input  32*LINE_SIZE*N_PORTS  per-port write line
- `wmask`  input  LINE_SIZE*N_PORTS  per-port word write enables
- `done`  output  N_PORTS  one-cycle completion pulse to the served port
- `rdata`  output  32*LINE_SIZE  last read line, shared by all ports
- `busy`  output  1  high whenever state ≠ IDLE

## Operation
- Line word ordering: word 0 occupies the most significant 32 bits of a line (`wdata`, `rdata`); word 0 ↔ `wmask[0]` of the port slice.
- RAM word address for word k: `{4'b0, addr[27:LINE_ADDR_LEN+2], k[LINE_ADDR_LEN-1:0], 2'b00}`; low `LINE_ADDR_LEN+2` address bits and bits [31:28] ignored.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE: if any `rd_req|wr_req` set, grant one port round-robin, capture its addr, wdata, wmask, op, reset counter → ACCESS. Same port with both bits set: read wins.
- Round-robin: search starts at `last+1` (mod N_PORTS); `last` updated to granted port on acceptance; reset value N_PORTS-1 (port 0 first).
- ACCESS write: cycles 1..LINE_SIZE drive word k=cnt-1; `ram_write = wmask[k]`; masked-off words leave RAM unchanged.
- ACCESS read: cycles 1..LINE_SIZE drive address k; data for word k captured one cycle later (RAM has 1-cycle read latency); ACCESS spans LINE_SIZE+1 cycles.
- WAIT: idle until counter reaches LATENCY; `ram_write` low.
- DONE: `done[grant]` high one cycle; for reads `rdata` updated with captured line on entry to DONE, then held until next read's DONE (writes do not disturb it) → IDLE.
- Requester must drop its request by the edge following `done`; a request still high in IDLE is a new request.

## Timing
- Accept at edge i → `done` high from edge i+LATENCY for one cycle → IDLE at edge i+LATENCY+1 → earliest next acceptance edge i+LATENCY+2.
- Latency identical for reads, writes, any mask, any port.
- Reset (rst low, asynchronous): state IDLE, `done`=0, `rdata`=0, `busy`=0, `ram_write`=0, RAM address/data regs 0, counter 0, `last`=N_PORTS-1. RAM contents untouched. Reset mid-ACCESS aborts the line; partially written words remain.
- Requests arriving while busy are not lost: they are held by the requester and arbitrated in the next IDLE.
- Counter width ≥ clog2(LATENCY+1); no wrap during a transaction.

## Structure
- Shared header/package: state encodings, `LINE_SIZE`, word-offset width, `WORD_ADDR_LEN=2`, line-word slice helper.
- Sub-module `rr_arbiter` (N_PORTS request vector, `last` pointer in, one-hot grant + index out, combinational).
- Existing `RAM` instantiated once.

## Test plan
- Single port 0 write line 0x1..0x8 to 0x100 mask 0xFF, then read 0x100 → `rdata` = 0x1..0x8 (word 0 MSB), each `done` exactly 17 cycles after acceptance.
- Write 0xA.. line mask 0x05 over prior line → read returns words 0,2 new, others old.
- Ports 0 and 1 both request continuously → grants alternate 0,1,0,1; each `done` only on granted port, back-to-back spacing LATENCY+2 cycles.
- Address 0x1000_0104 read → same data as 0x0000_0100 (alignment and [31:28] masking).
- Assert `rst` low mid-ACCESS of a write → `done`, `busy`, `ram_write` drop immediately; after release, new read completes normally.
- Same port `rd_req`=`wr_req`=1 → read performed, RAM unchanged; `LINE_ADDR_LEN=2, LATENCY=6` build passes scenarios 1–3.
